// File: rtl/data_mem_arbiter_pkg.sv
// Shared types for the DataMemory arbiter: FSM states, port ids and the
// read-return tag that travels alongside each memory read.
package data_mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB       = 2'd0,
    LD_FORCE  = 2'd1,
    LD_LOCKED = 2'd2
  } arb_state_t;

  typedef enum logic {
    PORT_CPU = 1'b0,
    PORT_LD  = 1'b1
  } port_id_t;

  typedef struct packed {
    logic     valid;
    port_id_t port;
  } rd_tag_t;

  // Writes still occupy a slot in the tag pipe, just with valid cleared.
  function automatic rd_tag_t make_tag(input logic is_read, input port_id_t port);
    rd_tag_t t;
    t.valid = is_read;
    t.port  = port;
    return t;
  endfunction

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Bus bundle for the arbiter: CPU data port, loader port and DataMemory side.
// The arbiter uses the slave view; requesters and memory use the master view.
interface data_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_stall;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              ld_req;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic              ld_lock;
  logic              ld_gnt;
  logic              ld_rvalid;
  logic [DATA_W-1:0] ld_rdata;

  logic [ADDR_W-1:0] mem_a;
  logic [DATA_W-1:0] mem_wd;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rd;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
    input  ld_req, ld_we, ld_addr, ld_wdata, ld_lock,
    output ld_gnt, ld_rvalid, ld_rdata,
    output mem_a, mem_wd, mem_we,
    input  mem_rd
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
    output ld_req, ld_we, ld_addr, ld_wdata, ld_lock,
    input  ld_gnt, ld_rvalid, ld_rdata,
    input  mem_a, mem_wd, mem_we,
    output mem_rd
  );

endinterface

// File: rtl/data_mem_arbiter_rd_tag_pipe.sv
// Delay line for read-return tags; its depth matches the memory read latency
// so the tag leaves the pipe in the same cycle its data appears on mem_rd.
module rd_tag_pipe
  import data_mem_arb_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic    clk,
  input  logic    rst_n,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);

  rd_tag_t [DEPTH-1:0] stage_q;
  rd_tag_t [DEPTH-1:0] stage_d;

  always_comb begin
    stage_d    = stage_q;
    stage_d[0] = tag_in;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // Clearing on reset drops every tag in flight, so no stale rvalid survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the single-port DataMemory between the CPU data port and the loader
// port: fixed CPU priority, a starvation guard for LD, and an LD lock.
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 1,
  parameter int STARVE_LIM = 4
) (
  input logic               clk,
  input logic               reset,
  data_mem_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(STARVE_LIM + 1);
  localparam logic [CNT_W-1:0] CNT_FORCE_AT = CNT_W'(STARVE_LIM - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  arb_state_t        state_q;
  arb_state_t        state_d;
  logic [CNT_W-1:0]  starve_cnt_q;
  logic [CNT_W-1:0]  starve_cnt_d;

  logic              cpu_gnt;
  logic              ld_gnt;
  logic [ADDR_W-1:0] mem_a;
  logic [DATA_W-1:0] mem_wd;
  logic              mem_we;
  logic              rd_issue;
  rd_tag_t           push_tag;
  rd_tag_t           pop_tag;

  // Grants are decided from the live requests and the registered state; while
  // reset is held nothing is granted even if a requester is already asking.
  always_comb begin
    cpu_gnt      = 1'b0;
    ld_gnt       = 1'b0;
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    if (reset) begin
      unique case (state_q)
        ARB: begin
          cpu_gnt = bus.cpu_req;
          ld_gnt  = bus.ld_req & ~bus.cpu_req;
          if (bus.ld_req && !ld_gnt) begin
            starve_cnt_d = starve_cnt_q + CNT_ONE;
            if (starve_cnt_q == CNT_FORCE_AT) begin
              state_d = LD_FORCE;
            end
          end else begin
            starve_cnt_d = '0;
          end
          if (ld_gnt && bus.ld_lock) begin
            state_d = LD_LOCKED;
          end
        end
        LD_FORCE: begin
          ld_gnt       = bus.ld_req;
          cpu_gnt      = bus.cpu_req & ~bus.ld_req;
          starve_cnt_d = '0;
          state_d      = (ld_gnt && bus.ld_lock) ? LD_LOCKED : ARB;
        end
        LD_LOCKED: begin
          ld_gnt       = bus.ld_req;
          starve_cnt_d = '0;
          if (!bus.ld_lock) begin
            state_d = ARB;
          end
        end
        default: begin
          state_d      = ARB;
          starve_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ARB;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Memory-side mux: an idle cycle drives all zeros so the bus is quiet.
  always_comb begin
    mem_a    = '0;
    mem_wd   = '0;
    mem_we   = 1'b0;
    rd_issue = 1'b0;
    if (ld_gnt) begin
      mem_a    = bus.ld_addr;
      mem_wd   = bus.ld_wdata;
      mem_we   = bus.ld_we;
      rd_issue = ~bus.ld_we;
    end else if (cpu_gnt) begin
      mem_a    = bus.cpu_addr;
      mem_wd   = bus.cpu_wdata;
      mem_we   = bus.cpu_we;
      rd_issue = ~bus.cpu_we;
    end
  end

  assign push_tag = make_tag(rd_issue, ld_gnt ? PORT_LD : PORT_CPU);

  rd_tag_pipe #(
    .DEPTH (RD_LAT)
  ) u_rd_tag_pipe (
    .clk     (clk),
    .rst_n   (reset),
    .tag_in  (push_tag),
    .tag_out (pop_tag)
  );

  assign bus.mem_a      = mem_a;
  assign bus.mem_wd     = mem_wd;
  assign bus.mem_we     = mem_we;

  assign bus.cpu_gnt    = cpu_gnt;
  assign bus.cpu_stall  = reset & bus.cpu_req & ~cpu_gnt;
  assign bus.ld_gnt     = ld_gnt;

  assign bus.cpu_rvalid = pop_tag.valid & (pop_tag.port == PORT_CPU);
  assign bus.ld_rvalid  = pop_tag.valid & (pop_tag.port == PORT_LD);
  assign bus.cpu_rdata  = bus.mem_rd;
  assign bus.ld_rdata   = bus.mem_rd;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: directed scenarios with literal
// expectations plus randomized traffic checked against a behavioural model.
module tb_data_mem_arbiter;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int RD_LAT     = 2;
  localparam int STARVE_LIM = 4;

  logic clk;
  logic reset;

  data_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_if ();

  data_mem_arbiter #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .RD_LAT     (RD_LAT),
    .STARVE_LIM (STARVE_LIM)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;

  function automatic logic [31:0] init_word(input int i);
    if (i == 4) return 32'hDEAD_BEEF;
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  // DataMemory stand-in: word addressed, read data RD_LAT cycles after the address cycle.
  logic [31:0] env_mem  [0:255];
  logic [31:0] rd_stage [RD_LAT];
  bit          mem_loaded;

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 256; i++) env_mem[i] <= init_word(i);
      mem_loaded <= 1'b1;
    end else begin
      if (bus_if.mem_we) env_mem[bus_if.mem_a[9:2]] <= bus_if.mem_wd;
      rd_stage[0] <= env_mem[bus_if.mem_a[9:2]];
      for (int i = 1; i < RD_LAT; i++) rd_stage[i] <= rd_stage[i-1];
    end
  end
  assign bus_if.mem_rd = rd_stage[RD_LAT-1];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Behavioural model: who may use the memory this cycle, and a queue of
  // expected read returns, one slot per cycle of read latency.
  typedef struct {
    bit          valid;
    bit          is_ld;
    logic [31:0] data;
  } ret_t;

  ret_t        ret_q[$];
  logic [31:0] shadow [0:255];
  bit          m_locked;
  bit          m_force;
  int          m_denied;
  bit          m_cpu_gnt_now;
  bit          m_ld_gnt_now;
  bit          model_en;
  int          ld_wait_run;
  int          ld_wait_max;

  task automatic resetModel();
    m_locked = 1'b0;
    m_force  = 1'b0;
    m_denied = 0;
    ret_q.delete();
    for (int i = 0; i < RD_LAT; i++) ret_q.push_back('{valid: 1'b0, is_ld: 1'b0, data: 32'h0});
  endtask

  task automatic compareModel();
    bit          e_cpu, e_ld, e_we, e_stall;
    logic [31:0] e_a, e_wd;
    ret_t        head, nw;
    if (!reset) begin
      checkOutput("rst_cpu_gnt", bus_if.cpu_gnt, 0);
      checkOutput("rst_ld_gnt", bus_if.ld_gnt, 0);
      checkOutput("rst_cpu_stall", bus_if.cpu_stall, 0);
      checkOutput("rst_mem_we", bus_if.mem_we, 0);
      checkOutput("rst_cpu_rvalid", bus_if.cpu_rvalid, 0);
      checkOutput("rst_ld_rvalid", bus_if.ld_rvalid, 0);
      resetModel();
      m_cpu_gnt_now = 1'b0;
      m_ld_gnt_now  = 1'b0;
      ld_wait_run   = 0;
      return;
    end
    if (m_locked) begin
      e_ld  = bus_if.ld_req;
      e_cpu = 1'b0;
    end else if (m_force) begin
      e_ld  = bus_if.ld_req;
      e_cpu = bus_if.cpu_req && !bus_if.ld_req;
    end else begin
      e_cpu = bus_if.cpu_req;
      e_ld  = bus_if.ld_req && !bus_if.cpu_req;
    end
    e_stall = bus_if.cpu_req && !e_cpu;
    e_we = 1'b0; e_a = 32'h0; e_wd = 32'h0;
    if (e_ld) begin
      e_we = bus_if.ld_we; e_a = bus_if.ld_addr; e_wd = bus_if.ld_wdata;
    end else if (e_cpu) begin
      e_we = bus_if.cpu_we; e_a = bus_if.cpu_addr; e_wd = bus_if.cpu_wdata;
    end
    head = ret_q.pop_front();
    checkOutput("cpu_gnt", bus_if.cpu_gnt, e_cpu);
    checkOutput("ld_gnt", bus_if.ld_gnt, e_ld);
    checkOutput("cpu_stall", bus_if.cpu_stall, e_stall);
    checkOutput("mem_we", bus_if.mem_we, e_we);
    checkOutput("mem_a", bus_if.mem_a, e_a);
    checkOutput("mem_wd", bus_if.mem_wd, e_wd);
    checkOutput("cpu_rvalid", bus_if.cpu_rvalid, head.valid && !head.is_ld);
    checkOutput("ld_rvalid", bus_if.ld_rvalid, head.valid && head.is_ld);
    if (head.valid && head.is_ld)  checkOutput("ld_rdata", bus_if.ld_rdata, head.data);
    if (head.valid && !head.is_ld) checkOutput("cpu_rdata", bus_if.cpu_rdata, head.data);

    nw.valid = (e_cpu || e_ld) && !e_we;
    nw.is_ld = e_ld;
    nw.data  = shadow[e_a[9:2]];
    ret_q.push_back(nw);
    if ((e_cpu || e_ld) && e_we) shadow[e_a[9:2]] = e_wd;

    // LD is held off at most STARVE_LIM cycles; a lock persists until ld_lock drops.
    if (m_locked) begin
      m_locked = bus_if.ld_lock;
    end else begin
      if (m_force) begin
        m_force  = 1'b0;
        m_denied = 0;
      end else if (bus_if.ld_req && !e_ld) begin
        m_denied++;
        if (m_denied >= STARVE_LIM) m_force = 1'b1;
      end else begin
        m_denied = 0;
      end
      m_locked = e_ld && bus_if.ld_lock;
    end
    m_cpu_gnt_now = e_cpu;
    m_ld_gnt_now  = e_ld;

    if (bus_if.ld_req && !bus_if.ld_gnt) ld_wait_run++;
    else ld_wait_run = 0;
    if (ld_wait_run > ld_wait_max) ld_wait_max = ld_wait_run;
  endtask

  always @(negedge clk) begin
    if (model_en) compareModel();
  end

  task automatic nextCycle();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic driveCpu(input bit req, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
    bus_if.cpu_req   = req;
    bus_if.cpu_we    = we;
    bus_if.cpu_addr  = addr;
    bus_if.cpu_wdata = wdata;
  endtask

  task automatic driveLd(input bit req, input bit we, input logic [31:0] addr, input logic [31:0] wdata, input bit lock);
    bus_if.ld_req   = req;
    bus_if.ld_we    = we;
    bus_if.ld_addr  = addr;
    bus_if.ld_wdata = wdata;
    bus_if.ld_lock  = lock;
  endtask

  task automatic driveIdle();
    driveCpu(1'b0, 1'b0, 32'h0, 32'h0);
    driveLd(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  // Random traffic: a pending request keeps its address/data until granted.
  task automatic applyStimulus();
    if (!(bus_if.cpu_req && !m_cpu_gnt_now)) begin
      driveCpu($urandom_range(3) != 0, 1'($urandom_range(1)), 32'($urandom_range(63)) << 2, $urandom);
    end
    if (!(bus_if.ld_req && !m_ld_gnt_now)) begin
      bus_if.ld_req   = m_locked ? ($urandom_range(3) != 0) : ($urandom_range(1) != 0);
      bus_if.ld_we    = 1'($urandom_range(1));
      bus_if.ld_addr  = 32'($urandom_range(63)) << 2;
      bus_if.ld_wdata = $urandom;
    end
    bus_if.ld_lock = m_locked ? ($urandom_range(3) != 0) : ($urandom_range(9) == 0);
  endtask

  initial begin
    n_checks = 0; n_fail = 0; model_en = 1'b0;
    ld_wait_run = 0; ld_wait_max = 0;
    m_cpu_gnt_now = 1'b0; m_ld_gnt_now = 1'b0;
    for (int i = 0; i < 256; i++) shadow[i] = init_word(i);
    resetModel();
    driveIdle();
    reset = 1'b0;
    @(posedge clk);
    #2;
    model_en = 1'b1;

    // Requests during reset must not be granted or stall.
    driveCpu(1'b1, 1'b0, 32'h10, 32'h0);
    settle();
    checkOutput("reset_cpu_gnt", bus_if.cpu_gnt, 0);
    checkOutput("reset_cpu_stall", bus_if.cpu_stall, 0);
    nextCycle();
    reset = 1'b1;
    driveIdle();
    nextCycle();

    $display("[TB] CPU-only read of 0x10");
    driveCpu(1'b1, 1'b0, 32'h10, 32'h0);
    settle();
    checkOutput("t1_cpu_gnt", bus_if.cpu_gnt, 1);
    checkOutput("t1_mem_a", bus_if.mem_a, 32'h10);
    nextCycle();
    driveIdle();
    repeat (RD_LAT - 1) nextCycle();
    settle();
    checkOutput("t1_cpu_rvalid", bus_if.cpu_rvalid, 1);
    checkOutput("t1_cpu_rdata", bus_if.cpu_rdata, 32'hDEAD_BEEF);
    checkOutput("t1_ld_rvalid", bus_if.ld_rvalid, 0);
    repeat (2) nextCycle();

    $display("[TB] both ports requesting continuously");
    driveCpu(1'b1, 1'b0, 32'h0, 32'h0);
    driveLd(1'b1, 1'b0, 32'h4, 32'h0, 1'b0);
    for (int c = 0; c < 6; c++) begin
      settle();
      checkOutput($sformatf("t2_cpu_gnt_c%0d", c), bus_if.cpu_gnt, (c != 4));
      checkOutput($sformatf("t2_ld_gnt_c%0d", c), bus_if.ld_gnt, (c == 4));
      if (c == 4) checkOutput("t2_cpu_stall_c4", bus_if.cpu_stall, 1);
      nextCycle();
    end
    driveIdle();
    repeat (RD_LAT + 1) nextCycle();

    $display("[TB] locked LD burst with CPU waiting");
    driveLd(1'b1, 1'b1, 32'h20, 32'h0000_00AA, 1'b1);
    settle();
    checkOutput("t3_ld_gnt_c0", bus_if.ld_gnt, 1);
    checkOutput("t3_mem_we_c0", bus_if.mem_we, 1);
    checkOutput("t3_mem_wd_c0", bus_if.mem_wd, 32'h0000_00AA);
    nextCycle();
    for (int c = 1; c < 4; c++) begin
      driveCpu(1'b1, 1'b0, 32'h0, 32'h0);
      driveLd(1'b1, 1'b1, 32'h20 + 32'(4 * c), 32'h0000_00AA + 32'(c), (c != 3));
      settle();
      checkOutput($sformatf("t3_cpu_gnt_c%0d", c), bus_if.cpu_gnt, 0);
      checkOutput($sformatf("t3_ld_gnt_c%0d", c), bus_if.ld_gnt, 1);
      checkOutput($sformatf("t3_cpu_stall_c%0d", c), bus_if.cpu_stall, 1);
      nextCycle();
    end
    driveLd(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    settle();
    checkOutput("t3_cpu_gnt_after", bus_if.cpu_gnt, 1);
    nextCycle();
    driveIdle();
    repeat (RD_LAT + 1) nextCycle();

    $display("[TB] CPU write grant");
    driveCpu(1'b1, 1'b1, 32'h8, 32'h1234);
    settle();
    checkOutput("t6_mem_we", bus_if.mem_we, 1);
    checkOutput("t6_mem_a", bus_if.mem_a, 32'h8);
    checkOutput("t6_mem_wd", bus_if.mem_wd, 32'h1234);
    nextCycle();
    driveIdle();
    repeat (RD_LAT - 1) nextCycle();
    settle();
    checkOutput("t6_cpu_rvalid", bus_if.cpu_rvalid, 0);
    checkOutput("t6_ld_rvalid", bus_if.ld_rvalid, 0);
    nextCycle();

    $display("[TB] alternating CPU/LD reads");
    for (int c = 0; c < 4 + RD_LAT; c++) begin
      driveIdle();
      if (c < 4) begin
        if (c % 2 == 0) driveCpu(1'b1, 1'b0, 32'h0, 32'h0);
        else            driveLd(1'b1, 1'b0, 32'h4, 32'h0, 1'b0);
      end
      settle();
      if (c >= RD_LAT) begin
        if ((c - RD_LAT) % 2 == 0) begin
          checkOutput($sformatf("t4_cpu_rvalid_c%0d", c), bus_if.cpu_rvalid, 1);
          checkOutput($sformatf("t4_ld_rvalid_c%0d", c), bus_if.ld_rvalid, 0);
          checkOutput($sformatf("t4_cpu_rdata_c%0d", c), bus_if.cpu_rdata, 32'hC0DE_0000);
        end else begin
          checkOutput($sformatf("t4_ld_rvalid_c%0d", c), bus_if.ld_rvalid, 1);
          checkOutput($sformatf("t4_cpu_rvalid_c%0d", c), bus_if.cpu_rvalid, 0);
          checkOutput($sformatf("t4_ld_rdata_c%0d", c), bus_if.ld_rdata, 32'hC0DE_0001);
        end
      end
      nextCycle();
    end
    driveIdle();
    nextCycle();

    $display("[TB] reset with a read in flight");
    driveCpu(1'b1, 1'b0, 32'h0, 32'h0);
    settle();
    checkOutput("t5_cpu_gnt", bus_if.cpu_gnt, 1);
    nextCycle();
    driveCpu(1'b1, 1'b0, 32'h0, 32'h0);
    driveLd(1'b1, 1'b0, 32'h4, 32'h0, 1'b0);
    reset = 1'b0;
    #1;
    checkOutput("t5_cpu_gnt_rst", bus_if.cpu_gnt, 0);
    checkOutput("t5_ld_gnt_rst", bus_if.ld_gnt, 0);
    checkOutput("t5_cpu_stall_rst", bus_if.cpu_stall, 0);
    checkOutput("t5_cpu_rvalid_rst", bus_if.cpu_rvalid, 0);
    checkOutput("t5_ld_rvalid_rst", bus_if.ld_rvalid, 0);
    checkOutput("t5_mem_we_rst", bus_if.mem_we, 0);
    nextCycle();
    reset = 1'b1;
    driveIdle();
    for (int c = 0; c <= RD_LAT; c++) begin
      settle();
      checkOutput($sformatf("t5_cpu_rvalid_post%0d", c), bus_if.cpu_rvalid, 0);
      checkOutput($sformatf("t5_ld_rvalid_post%0d", c), bus_if.ld_rvalid, 0);
      nextCycle();
    end
    driveCpu(1'b1, 1'b0, 32'h0, 32'h0);
    driveLd(1'b1, 1'b0, 32'h4, 32'h0, 1'b0);
    for (int c = 0; c <= STARVE_LIM; c++) begin
      settle();
      checkOutput($sformatf("t5_ld_gnt_c%0d", c), bus_if.ld_gnt, (c == STARVE_LIM));
      nextCycle();
    end
    driveIdle();
    repeat (RD_LAT + 1) nextCycle();

    $display("[TB] randomized traffic");
    ld_wait_max = 0;
    for (int n = 0; n < 1500; n++) begin
      applyStimulus();
      nextCycle();
    end
    driveIdle();
    repeat (RD_LAT + 2) nextCycle();

    n_checks++;
    if (ld_wait_max > STARVE_LIM) begin
      n_fail++;
      $display("[TB] FAIL ld_wait_bound: longest LD wait %0d cycles, limit %0d", ld_wait_max, STARVE_LIM);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
